// File: rtl/event_stream_tx.sv
// event_stream_tx
//   Transmitter end of the event interface. Host writes are buffered in a FIFO
//   and replayed one event at a time under consumer back-pressure (event_req),
//   with an optional minimum idle gap after every accepted event.
//
// Parameters
//   DATA_WIDTH  event value width
//   FIFO_DEPTH  host buffer entries (power of 2, >= 2)
//   MIN_GAP     idle cycles forced after each accepted event (0 = back-to-back)
//
// Ports
//   clk, rst_n                   rising-edge clock, async active-low reset
//   enable                       allows popping new events from the FIFO
//   host_wr_en/value/addr        host write of one event into the FIFO
//   host_full, fifo_level        FIFO status (derived from the pointers)
//   event_req                    consumer ready; transfer = valid & event_req
//   out_event_valid/value/addr   registered presented event
//   sent_count                   accepted transfers (wrapping)
//   drop_count                   writes lost to a full FIFO (saturating)
module event_stream_tx #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned MIN_GAP    = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          host_wr_en,
  input  logic [DATA_WIDTH-1:0]         host_wr_value,
  input  logic [15:0]                   host_wr_addr,
  output logic                          host_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          event_req,
  output logic                          out_event_valid,
  output logic [DATA_WIDTH-1:0]         out_event_value,
  output logic [15:0]                   out_event_addr,
  output logic [31:0]                   sent_count,
  output logic [15:0]                   drop_count
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned EW     = DATA_WIDTH + 16;
  localparam int unsigned GW     = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam bit          GAP_EN = (MIN_GAP > 0);

  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [GW-1:0] GAP_ONE  = 1;
  localparam logic [GW-1:0] GAP_INIT = GW'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t          state;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [EW-1:0]   rd_data;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [GW-1:0]   gap_cnt;
  logic            wr_accept;
  logic            pop;

  // Pointers carry one extra MSB, so the difference is the true occupancy
  // and its MSB alone marks the full condition.
  assign fifo_level = wr_ptr - rd_ptr;
  assign host_full  = fifo_level[AW];

  // A write that meets a full FIFO is dropped even if a pop frees a slot on
  // the same edge.
  assign wr_accept = host_wr_en && !host_full;

  // Pop from IDLE, or straight from SEND on a transfer when no gap is needed,
  // which is what gives one event every two cycles at full rate.
  assign pop = enable && (fifo_level != '0) &&
               ((state == IDLE) || ((state == SEND) && event_req && !GAP_EN));

  // Buffer storage and synchronous read port, kept reset-free for RAM mapping.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[AW-1:0]] <= {host_wr_value, host_wr_addr};
    end
    if (pop) begin
      rd_data <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      state           <= IDLE;
      gap_cnt         <= '0;
      out_event_valid <= 1'b0;
      out_event_value <= '0;
      out_event_addr  <= '0;
      sent_count      <= '0;
      drop_count      <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else if (host_wr_en && (drop_count != '1)) begin
        drop_count <= drop_count + 16'd1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          {out_event_value, out_event_addr} <= rd_data;
          out_event_valid <= 1'b1;
          state           <= SEND;
        end
        SEND: begin
          if (event_req) begin
            sent_count      <= sent_count + 32'd1;
            out_event_valid <= 1'b0;
            if (GAP_EN) begin
              gap_cnt <= GAP_INIT;
              state   <= GAP;
            end else if (pop) begin
              state <= LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_event_stream_tx.sv
// tb_event_stream_tx
//   Directed-vector bench for event_stream_tx. A back-to-back instance covers
//   reset, latency, back-pressure, enable, overflow and drop saturation; a
//   second instance with MIN_GAP=3 covers the inter-event gap timing.
module tb_event_stream_tx;

  logic        clk;
  logic        rst_n;

  logic        enable;
  logic        host_wr_en;
  logic [3:0]  host_wr_value;
  logic [15:0] host_wr_addr;
  logic        host_full;
  logic [5:0]  fifo_level;
  logic        event_req;
  logic        out_event_valid;
  logic [3:0]  out_event_value;
  logic [15:0] out_event_addr;
  logic [31:0] sent_count;
  logic [15:0] drop_count;

  logic        g_enable;
  logic        g_wr_en;
  logic [3:0]  g_wr_value;
  logic [15:0] g_wr_addr;
  logic        g_full;
  logic [5:0]  g_level;
  logic        g_req;
  logic        g_valid;
  logic [3:0]  g_value;
  logic [15:0] g_addr;
  logic [31:0] g_sent;
  logic [15:0] g_drop;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [19:0] exp_q[$];

  event_stream_tx #(.DATA_WIDTH(4), .FIFO_DEPTH(32), .MIN_GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .host_wr_en(host_wr_en), .host_wr_value(host_wr_value), .host_wr_addr(host_wr_addr),
    .host_full(host_full), .fifo_level(fifo_level), .event_req(event_req),
    .out_event_valid(out_event_valid), .out_event_value(out_event_value),
    .out_event_addr(out_event_addr), .sent_count(sent_count), .drop_count(drop_count)
  );

  event_stream_tx #(.DATA_WIDTH(4), .FIFO_DEPTH(32), .MIN_GAP(3)) dut_gap (
    .clk(clk), .rst_n(rst_n), .enable(g_enable),
    .host_wr_en(g_wr_en), .host_wr_value(g_wr_value), .host_wr_addr(g_wr_addr),
    .host_full(g_full), .fifo_level(g_level), .event_req(g_req),
    .out_event_valid(g_valid), .out_event_value(g_value),
    .out_event_addr(g_addr), .sent_count(g_sent), .drop_count(g_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one write for a single cycle; caller drops host_wr_en afterwards.
  task automatic push(input logic [3:0] v, input logic [15:0] a, input bit record);
    host_wr_en    = 1'b1;
    host_wr_value = v;
    host_wr_addr  = a;
    if (record) exp_q.push_back({v, a});
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    tick();
  endtask

  // Holds event_req high and checks every presented event against the queue.
  task automatic drain(input string tag, input int n, input int budget);
    int got;
    logic [19:0] e;
    got = 0;
    event_req = 1'b1;
    for (int c = 0; c < budget && got < n; c++) begin
      if (out_event_valid) begin
        e = exp_q.pop_front();
        check($sformatf("%s_value%0d", tag, got), 32'(out_event_value), 32'(e[19:16]));
        check($sformatf("%s_addr%0d", tag, got), 32'(out_event_addr), 32'(e[15:0]));
        got++;
      end
      tick();
    end
    check({tag, "_count"}, 32'(got), 32'(n));
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    enable = 1'b1; host_wr_en = 1'b0; host_wr_value = '0; host_wr_addr = '0; event_req = 1'b0;
    g_enable = 1'b1; g_wr_en = 1'b0; g_wr_value = '0; g_wr_addr = '0; g_req = 1'b0;
    tick();
    check("rst_valid", 32'(out_event_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_full",  32'(host_full), 32'd0);
    check("rst_sent",  sent_count, 32'd0);
    check("rst_drop",  32'(drop_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single event: valid appears three edges after the write, for one cycle.
    event_req = 1'b1;
    push(4'h5, 16'h0A0B, 1'b0);
    host_wr_en = 1'b0;
    check("single_level", 32'(fifo_level), 32'd1);
    check("single_v_t1", 32'(out_event_valid), 32'd0);
    tick();
    check("single_v_t2", 32'(out_event_valid), 32'd0);
    tick();
    check("single_v_t3", 32'(out_event_valid), 32'd1);
    check("single_value", 32'(out_event_value), 32'h5);
    check("single_addr", 32'(out_event_addr), 32'h0A0B);
    tick();
    check("single_v_t4", 32'(out_event_valid), 32'd0);
    check("single_sent", sent_count, 32'd1);
    check("single_lvl0", 32'(fifo_level), 32'd0);

    // Asynchronous reset while an event is presented.
    event_req = 1'b0;
    push(4'h9, 16'h1234, 1'b0);
    host_wr_en = 1'b0;
    tick(); tick();
    check("mid_send_valid", 32'(out_event_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_event_valid), 32'd0);
    check("async_value", 32'(out_event_value), 32'd0);
    check("async_addr",  32'(out_event_addr), 32'd0);
    check("async_sent",  sent_count, 32'd0);
    check("async_level", 32'(fifo_level), 32'd0);
    check("async_full",  32'(host_full), 32'd0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    tick(); tick(); tick();
    check("post_rst_level", 32'(fifo_level), 32'd0);
    check("post_rst_valid", 32'(out_event_valid), 32'd0);

    // Back-pressure: first event held stable, the rest stay queued.
    event_req = 1'b0;
    push(4'h1, 16'h0101, 1'b1);
    push(4'h2, 16'h0202, 1'b1);
    push(4'h3, 16'h0303, 1'b1);
    host_wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold_valid%0d", i), 32'(out_event_valid), 32'd1);
      check($sformatf("bp_hold_value%0d", i), 32'(out_event_value), 32'h1);
      check($sformatf("bp_hold_addr%0d", i), 32'(out_event_addr), 32'h0101);
      tick();
    end
    check("bp_level", 32'(fifo_level), 32'd2);
    drain("bp", 3, 30);
    check("bp_sent", sent_count, 32'd3);
    check("bp_level0", 32'(fifo_level), 32'd0);

    // Enable low blocks popping; raising it releases both events.
    event_req = 1'b0;
    enable = 1'b0;
    push(4'h7, 16'hBEEF, 1'b1);
    push(4'hC, 16'hCAFE, 1'b1);
    host_wr_en = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("en_valid", 32'(out_event_valid), 32'd0);
    check("en_level", 32'(fifo_level), 32'd2);
    enable = 1'b1;
    drain("en", 2, 30);
    check("en_sent", sent_count, 32'd5);

    // Overflow: 1 in the output register + 32 stored, the 34th is dropped.
    do_reset();
    event_req = 1'b0;
    for (int i = 0; i < 34; i++) begin
      push(4'(i), 16'(16'h1000 + i), i < 33);
    end
    host_wr_en = 1'b0;
    tick(); tick();
    check("ovf_full",  32'(host_full), 32'd1);
    check("ovf_level", 32'(fifo_level), 32'd32);
    check("ovf_drop",  32'(drop_count), 32'd1);
    check("ovf_valid", 32'(out_event_valid), 32'd1);
    drain("ovf", 33, 120);
    for (int i = 0; i < 10; i++) tick();
    check("ovf_no34", 32'(out_event_valid), 32'd0);
    check("ovf_sent", sent_count, 32'd33);
    check("ovf_empty", 32'(fifo_level), 32'd0);
    check("ovf_notfull", 32'(host_full), 32'd0);

    // Drop counter saturation: writes 34 onward into a full FIFO each drop one.
    do_reset();
    event_req = 1'b0;
    host_wr_en = 1'b1;
    host_wr_value = 4'h3;
    host_wr_addr = 16'h4444;
    for (int i = 0; i < 33 + 65534; i++) tick();
    check("sat_fffe", 32'(drop_count), 32'hFFFE);
    tick();
    check("sat_ffff", 32'(drop_count), 32'hFFFF);
    for (int i = 0; i < 10; i++) tick();
    check("sat_hold", 32'(drop_count), 32'hFFFF);
    host_wr_en = 1'b0;

    // Gap instance: valid pulses at edges 3, 9, 15, 21 after the first write.
    do_reset();
    g_req = 1'b1;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      g_wr_en    = (c < 4);
      g_wr_value = 4'(4'hA + c);
      g_wr_addr  = 16'(16'hB000 + c);
      tick();
      if (g_valid) begin
        check($sformatf("gap_edge%0d", pulses), 32'(c + 1), 32'(3 + 6 * pulses));
        check($sformatf("gap_value%0d", pulses), 32'(g_value), 32'(4'hA + pulses));
        check($sformatf("gap_addr%0d", pulses), 32'(g_addr), 32'(16'hB000 + pulses));
        pulses++;
      end
    end
    g_wr_en = 1'b0;
    check("gap_pulses", 32'(pulses), 32'd4);
    check("gap_sent", g_sent, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
